// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operand-issue / writeback sequencer:
// ALU opcodes, sequencer state encoding and flag bit positions.
package alu_seq_pkg;

  // ALU opcodes as seen on alu_opcode
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_INC = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  // Sequencer states; a load skips straight from IDLE to WB
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_WB      = 2'd3
  } state_t;

  // Bit positions inside the 4-bit flags word {zero, sign, ov, cout}
  localparam int FLG_COUT = 0;
  localparam int FLG_OV   = 1;
  localparam int FLG_SIGN = 2;
  localparam int FLG_ZERO = 3;
  localparam int NFLAGS   = 4;

  // Assemble a flags word from its individual bits
  function automatic logic [NFLAGS-1:0] pack_flags(input logic zero,
                                                   input logic sign,
                                                   input logic ov,
                                                   input logic cout);
    logic [NFLAGS-1:0] f;
    f           = '0;
    f[FLG_ZERO] = zero;
    f[FLG_SIGN] = sign;
    f[FLG_OV]   = ov;
    f[FLG_COUT] = cout;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Small register file for the sequencer: one synchronous write port,
// three combinational read ports (operand A, operand B, debug).
// Every entry is cleared asynchronously while rst_n is low.
module alu_seq_regfile #(
  parameter  int NREGS = 4,
  parameter  int DW    = 8,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [RW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [RW-1:0] ra_addr_i,
  output logic [DW-1:0] ra_data_o,
  input  logic [RW-1:0] rb_addr_i,
  output logic [DW-1:0] rb_data_o,
  input  logic [RW-1:0] dbg_addr_i,
  output logic [DW-1:0] dbg_data_o
);

  logic [DW-1:0] mem_q [NREGS];

  // Storage: cleared on reset, one entry written per enabled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports see the stored value; a write becomes visible the cycle after
  always_comb begin
    ra_data_o  = mem_q[ra_addr_i];
    rb_data_o  = mem_q[rb_addr_i];
    dbg_data_o = mem_q[dbg_addr_i];
  end

endmodule

// File: rtl/alu_reg_sequencer.sv
// Operand-issue and writeback stage wrapped around an external 8-bit ALU.
// Takes one command at a time, reads operands from the register file (or an
// immediate), presents them to the ALU from registers, captures the result a
// cycle later and writes it back while updating the sticky flags register.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE; there is no skid
// buffer, so a command offered while busy is simply not taken and the master
// keeps it on the bus until cmd_ready returns.
module alu_reg_sequencer
  import alu_seq_pkg::*;
#(
  parameter  int NREGS = 4,
  parameter  int DW    = 8,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  // command channel
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_load,
  input  logic [2:0]    cmd_opcode,
  input  logic [RW-1:0] cmd_rd,
  input  logic [RW-1:0] cmd_ra,
  input  logic [RW-1:0] cmd_rb,
  input  logic          cmd_use_imm,
  input  logic [DW-1:0] cmd_imm,
  // ALU side
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_opcode,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_ov,
  input  logic          alu_sign,
  input  logic          alu_cout,
  // completion and status
  output logic          done,
  output logic [DW-1:0] done_result,
  output logic [3:0]    flags,
  // debug
  input  logic [RW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic [1:0]    dbg_state
);

  state_t        state_q;
  // command fields held for the duration of the operation
  logic          load_q;
  logic [2:0]    opcode_q;
  logic [RW-1:0] rd_q;
  logic [RW-1:0] ra_q;
  logic [RW-1:0] rb_q;
  logic          use_imm_q;
  logic [DW-1:0] imm_q;
  // registered ALU drive
  logic [DW-1:0] alu_a_q;
  logic [DW-1:0] alu_b_q;
  logic [2:0]    alu_op_q;
  // captured ALU outcome; done_result_q doubles as the writeback data
  logic [DW-1:0] done_result_q;
  logic [3:0]    cap_flags_q;
  logic [3:0]    flags_q;
  logic          done_q;

  logic [DW-1:0] rf_a;
  logic [DW-1:0] rf_b;
  logic          wr_en_d;

  // Write happens at the edge that ends WB, after operands were already taken
  always_comb begin
    wr_en_d = (state_q == ST_WB);
  end

  alu_seq_regfile #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (wr_en_d),
    .waddr_i    (rd_q),
    .wdata_i    (done_result_q),
    .ra_addr_i  (ra_q),
    .ra_data_o  (rf_a),
    .rb_addr_i  (rb_q),
    .rb_data_o  (rf_b),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  // Sequencer FSM with all outputs registered; done_q is raised on the edge
  // entering WB so it is high for exactly the WB cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      load_q        <= 1'b0;
      opcode_q      <= '0;
      rd_q          <= '0;
      ra_q          <= '0;
      rb_q          <= '0;
      use_imm_q     <= 1'b0;
      imm_q         <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      done_result_q <= '0;
      cap_flags_q   <= '0;
      flags_q       <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            load_q    <= cmd_load;
            opcode_q  <= cmd_opcode;
            rd_q      <= cmd_rd;
            ra_q      <= cmd_ra;
            rb_q      <= cmd_rb;
            use_imm_q <= cmd_use_imm;
            imm_q     <= cmd_imm;
            if (cmd_load) begin
              done_result_q <= cmd_imm;
              done_q        <= 1'b1;
              state_q       <= ST_WB;
            end else begin
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          // operands come from the register file as it stands one cycle after accept
          alu_a_q  <= rf_a;
          alu_b_q  <= use_imm_q ? imm_q : rf_b;
          alu_op_q <= opcode_q;
          state_q  <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // ALU inputs have been stable for a full cycle; zero is derived here
          done_result_q <= alu_result;
          cap_flags_q   <= pack_flags(alu_result == '0, alu_sign, alu_ov, alu_cout);
          done_q        <= 1'b1;
          state_q       <= ST_WB;
        end
        ST_WB: begin
          if (!load_q) begin
            flags_q <= cap_flags_q;
          end
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output mapping from registered state
  always_comb begin
    cmd_ready   = (state_q == ST_IDLE);
    alu_a       = alu_a_q;
    alu_b       = alu_b_q;
    alu_opcode  = alu_op_q;
    done        = done_q;
    done_result = done_result_q;
    flags       = flags_q;
    dbg_state   = state_q;
  end

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Directed bench for alu_reg_sequencer wired to a behavioural 8-bit ALU.
module tb_alu_reg_sequencer;
  import alu_seq_pkg::*;

  localparam int NREGS = 4;
  localparam int DW    = 8;
  localparam int RW    = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_load = 1'b0;
  logic [2:0]    cmd_opcode = '0;
  logic [RW-1:0] cmd_rd = '0;
  logic [RW-1:0] cmd_ra = '0;
  logic [RW-1:0] cmd_rb = '0;
  logic          cmd_use_imm = 1'b0;
  logic [DW-1:0] cmd_imm = '0;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [2:0]    alu_opcode;
  logic [DW-1:0] alu_result;
  logic          alu_ov;
  logic          alu_sign;
  logic          alu_cout;
  logic          done;
  logic [DW-1:0] done_result;
  logic [3:0]    flags;
  logic [RW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_data;
  logic [1:0]    dbg_state;

  alu_reg_sequencer #(.NREGS(NREGS), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_load    (cmd_load),
    .cmd_opcode  (cmd_opcode),
    .cmd_rd      (cmd_rd),
    .cmd_ra      (cmd_ra),
    .cmd_rb      (cmd_rb),
    .cmd_use_imm (cmd_use_imm),
    .cmd_imm     (cmd_imm),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_result  (alu_result),
    .alu_ov      (alu_ov),
    .alu_sign    (alu_sign),
    .alu_cout    (alu_cout),
    .done        (done),
    .done_result (done_result),
    .flags       (flags),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .dbg_state   (dbg_state)
  );

  // ---------------- behavioural ALU ----------------
  always_comb begin
    logic [DW:0] sum;
    sum        = '0;
    alu_result = '0;
    alu_cout   = 1'b0;
    alu_ov     = 1'b0;
    case (alu_opcode)
      OP_ADD: begin
        sum        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum[DW-1:0];
        alu_cout   = sum[DW];
        alu_ov     = (alu_a[DW-1] == alu_b[DW-1]) && (sum[DW-1] != alu_a[DW-1]);
      end
      OP_INC: begin
        sum        = {1'b0, alu_a} + 9'd1;
        alu_result = sum[DW-1:0];
        alu_cout   = sum[DW];
        alu_ov     = (alu_a == 8'h7F);
      end
      OP_AND: alu_result = alu_a & alu_b;
      OP_OR:  alu_result = alu_a | alu_b;
      OP_XOR: alu_result = alu_a ^ alu_b;
      OP_NOT: alu_result = ~alu_a;
      OP_SHR: begin
        alu_result = alu_a >> 1;
        alu_cout   = alu_a[0];
      end
      default: begin
        alu_result = alu_a << 1;
        alu_cout   = alu_a[DW-1];
      end
    endcase
    alu_sign = alu_result[DW-1];
  end

  // ---------------- scoreboard / checks ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [RW-1:0] idx, input logic [DW-1:0] exp);
    dbg_addr = idx;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_cmd(input logic ld, input logic [2:0] op, input logic [RW-1:0] rd,
                         input logic [RW-1:0] ra, input logic [RW-1:0] rb,
                         input logic ui, input logic [DW-1:0] imm);
    cmd_load    = ld;
    cmd_opcode  = op;
    cmd_rd      = rd;
    cmd_ra      = ra;
    cmd_rb      = rb;
    cmd_use_imm = ui;
    cmd_imm     = imm;
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_ready_wait"}, cmd_ready, 1);
  endtask

  // Issue one command, wait for its done pulse and check latency/result
  task automatic run_cmd(input string tag, input logic ld, input logic [2:0] op,
                         input logic [RW-1:0] rd, input logic [RW-1:0] ra,
                         input logic [RW-1:0] rb, input logic ui,
                         input logic [DW-1:0] imm, input logic [DW-1:0] exp_res);
    int lat;
    set_cmd(ld, op, rd, ra, rb, ui, imm);
    cmd_valid = 1'b1;
    wait_ready(tag);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    set_cmd(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)));
    lat = 0;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, ld ? 0 : 2);
    chk({tag, "_done_result"}, done_result, exp_res);
    @(posedge clk); #1;
    chk({tag, "_done_low"}, done, 0);
    chk({tag, "_ready_back"}, cmd_ready, 1);
    chk({tag, "_result_held"}, done_result, exp_res);
    chk_reg({tag, "_rf_rd"}, rd, exp_res);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [DW-1:0] t4_exp [3];
    logic [DW-1:0] t4_got;
    int lows;
    int dones;
    int extra;
    t4_exp[0] = 8'hC0;
    t4_exp[1] = 8'h3F;
    t4_exp[2] = 8'hFF;

    // reset state
    #12;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready_after", cmd_ready, 1);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_done_result", done_result, 0);
    chk("rst_flags", flags, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_opcode, 0);
    for (int i = 0; i < NREGS; i++) chk_reg("rst_rf", 2'(i), 8'h00);

    // 1: 0x7F + 0x01 -> 0x80, sign and signed overflow
    run_cmd("t1_ld_r0", 1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 1'b0, 8'h7F, 8'h7F);
    run_cmd("t1_ld_r1", 1'b1, OP_ADD, 2'd1, 2'd0, 2'd0, 1'b0, 8'h01, 8'h01);
    run_cmd("t1_add", 1'b0, OP_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'h80);
    chk("t1_flags", flags, 4'b0110);
    chk("t1_alu_a", alu_a, 8'h7F);
    chk("t1_alu_b", alu_b, 8'h01);
    chk("t1_alu_op", alu_opcode, OP_ADD);

    // 2: INC in place wraps 0xFF -> 0x00; a load leaves flags alone
    run_cmd("t2_ld_r3", 1'b1, OP_ADD, 2'd3, 2'd0, 2'd0, 1'b0, 8'hFF, 8'hFF);
    chk("t2_flags_after_load", flags, 4'b0110);
    run_cmd("t2_inc", 1'b0, OP_INC, 2'd3, 2'd3, 2'd0, 1'b0, 8'h00, 8'h00);
    chk("t2_flags", flags, 4'b1001);
    chk("t2_operand_pre_write", alu_a, 8'hFF);
    chk("t2_alu_op", alu_opcode, OP_INC);

    // 3: SHL 0xC0 -> 0x80 with carry, then AND with immediate -> zero
    run_cmd("t3_ld_r0", 1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 1'b0, 8'hC0, 8'hC0);
    run_cmd("t3_shl", 1'b0, OP_SHL, 2'd1, 2'd0, 2'd2, 1'b0, 8'h00, 8'h80);
    chk("t3_shl_flags", flags, 4'b0101);
    run_cmd("t3_and_imm", 1'b0, OP_AND, 2'd1, 2'd1, 2'd2, 1'b1, 8'h0F, 8'h00);
    chk("t3_and_flags", flags, 4'b1000);
    chk("t3_alu_b_imm", alu_b, 8'h0F);

    // 4: cmd_valid held high across three back-to-back ALU commands
    //    R0=C0 R1=00 R2=80 R3=00 going in
    dones = 0;
    set_cmd(1'b0, OP_ADD, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00);
    cmd_valid = 1'b1;
    wait_ready("t4");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      exp_q.push_back(t4_exp[i]);
      if (i == 0) set_cmd(1'b0, OP_XOR, 2'd2, 2'd0, 2'd1, 1'b1, 8'hFF);
      else if (i == 1) set_cmd(1'b0, OP_OR, 2'd0, 2'd2, 2'd3, 1'b0, 8'h00);
      else cmd_valid = 1'b0;
      lows = 0;
      while (!cmd_ready && lows < 10) begin
        if (done) begin
          dones++;
          t4_got = done_result;
          if (exp_q.size() == 0) chk("t4_unexpected_done", 1, 0);
          else chk("t4_done_order", t4_got, exp_q.pop_front());
        end
        lows++;
        @(posedge clk); #1;
      end
      chk("t4_ready_low_cycles", lows, 3);
    end
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    chk("t4_done_count", dones, 3);
    chk("t4_no_extra_done", extra, 0);
    chk("t4_queue_empty", exp_q.size(), 0);
    chk_reg("t4_r0", 2'd0, 8'hFF);
    chk_reg("t4_r2", 2'd2, 8'h3F);
    chk_reg("t4_r3", 2'd3, 8'hC0);
    chk("t4_flags", flags, 4'b0100);

    // 5: reset asserted during CAPTURE of an ADD
    set_cmd(1'b0, OP_ADD, 2'd1, 2'd0, 2'd2, 1'b0, 8'h00);
    cmd_valid = 1'b1;
    wait_ready("t5");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("t5_state_issue", dbg_state, ST_ISSUE);
    @(posedge clk); #1;
    chk("t5_state_capture", dbg_state, ST_CAPTURE);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_state_in_reset", dbg_state, ST_IDLE);
    chk("t5_flags_in_reset", flags, 0);
    extra = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_ready_after_release", cmd_ready, 1);
    chk("t5_done_result", done_result, 0);
    chk("t5_flags", flags, 0);
    chk("t5_alu_a", alu_a, 0);
    for (int i = 0; i < NREGS; i++) chk_reg("t5_rf_cleared", 2'(i), 8'h00);
    repeat (4) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    chk("t5_no_done", extra, 0);

    // 6: load then immediately XOR the same register with 0xFF
    run_cmd("t6_ld_r2", 1'b1, OP_ADD, 2'd2, 2'd0, 2'd0, 1'b0, 8'h55, 8'h55);
    chk("t6_flags_after_load", flags, 0);
    run_cmd("t6_xor", 1'b0, OP_XOR, 2'd2, 2'd2, 2'd0, 1'b1, 8'hFF, 8'hAA);
    chk("t6_flags", flags, 4'b0100);
    run_cmd("t6_ld_zero", 1'b1, OP_ADD, 2'd2, 2'd0, 2'd0, 1'b0, 8'h00, 8'h00);
    chk("t6_flags_sticky", flags, 4'b0100);

    // 7: unary ops NOT and SHR through the same path
    run_cmd("t7_ld_r1", 1'b1, OP_ADD, 2'd1, 2'd0, 2'd0, 1'b0, 8'h81, 8'h81);
    run_cmd("t7_shr", 1'b0, OP_SHR, 2'd0, 2'd1, 2'd3, 1'b0, 8'h00, 8'h40);
    chk("t7_shr_flags", flags, 4'b0001);
    run_cmd("t7_not", 1'b0, OP_NOT, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00, 8'hBF);
    chk("t7_not_flags", flags, 4'b0100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
